// File: rtl/mcb_port_pkg.sv
// Shared definitions for the BRAM-backed MCB user-port model:
// instruction encodings, engine states and default widths.
package mcb_port_pkg;

  localparam int DATA_W_DEF = 128;
  localparam int INSTR_W    = 3;
  localparam int BL_W       = 6;
  localparam int ADDR_W     = 30;

  localparam logic [INSTR_W-1:0] INSTR_WR  = 3'b000;
  localparam logic [INSTR_W-1:0] INSTR_RD  = 3'b001;
  localparam logic [INSTR_W-1:0] INSTR_NOP = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RDWAIT
  } state_e;

  // Engine state a freshly popped command leads to; no-op/refresh stays idle.
  function automatic state_e instr_target(input logic [INSTR_W-1:0] instr);
    if ((instr & INSTR_NOP) != '0)
      return ST_IDLE;
    else if (instr[0] == INSTR_WR[0])
      return ST_WRITE;
    else if (instr[0] == INSTR_RD[0])
      return ST_READ;
    else
      return ST_IDLE;
  endfunction

endpackage

// File: rtl/mcb_bram_port_if.sv
// User-port signal bundle: command, write-data and read-data channels.
// The responder (memory side) uses slave, the cache-fill engine uses master.
interface mcb_bram_port_if
  import mcb_port_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int FIFO_AW = 6
);

  logic                 cmd_en;
  logic [INSTR_W-1:0]   cmd_instr;
  logic [BL_W-1:0]      cmd_bl;
  logic [ADDR_W-1:0]    cmd_byte_addr;
  logic                 cmd_empty;
  logic                 cmd_full;

  logic                 wr_en;
  logic [DATA_W-1:0]    wr_data;
  logic [DATA_W/8-1:0]  wr_mask;
  logic                 wr_full;
  logic                 wr_empty;
  logic [FIFO_AW:0]     wr_count;
  logic                 wr_underrun;
  logic                 wr_error;

  logic                 rd_en;
  logic [DATA_W-1:0]    rd_data;
  logic                 rd_full;
  logic                 rd_empty;
  logic [FIFO_AW:0]     rd_count;
  logic                 rd_error;

  modport slave (
    input  cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
    output cmd_empty, cmd_full,
    input  wr_en, wr_data, wr_mask,
    output wr_full, wr_empty, wr_count, wr_underrun, wr_error,
    input  rd_en,
    output rd_data, rd_full, rd_empty, rd_count, rd_error
  );

  modport master (
    output cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
    input  cmd_empty, cmd_full,
    output wr_en, wr_data, wr_mask,
    input  wr_full, wr_empty, wr_count, wr_underrun, wr_error,
    output rd_en,
    input  rd_data, rd_full, rd_empty, rd_count, rd_error
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// A push while full is accepted only when a valid pop frees a slot that cycle.
module sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = count[AW];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage arrays carry no reset; pointers and count define validity,
  // and leaving the array unreset lets it map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mcb_bram_port.sv
// Spartan-6 MCB user-port responder backed by block RAM: queues burst
// commands, drains the write FIFO into memory and fills the read FIFO.
module mcb_bram_port
  import mcb_port_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_AW  = 10,
  parameter int FIFO_AW = 6,
  parameter int CMD_AW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  mcb_bram_port_if.slave    bus
);

  localparam int MASK_W   = DATA_W / 8;
  localparam int CMD_W    = INSTR_W + BL_W + MEM_AW;
  localparam int WR_W     = DATA_W + MASK_W;
  localparam int RD_DEPTH = 1 << FIFO_AW;

  // Command FIFO stores only the word address; sub-word and high address bits drop here.
  logic [CMD_W-1:0]   cmd_din;
  logic [CMD_W-1:0]   cmd_dout;
  logic [CMD_AW:0]    cmd_count;
  logic               cmd_pop;
  logic [INSTR_W-1:0] cmd_instr;
  logic [BL_W-1:0]    cmd_bl;
  logic [MEM_AW-1:0]  cmd_addr;

  assign cmd_din = {bus.cmd_instr, bus.cmd_bl, bus.cmd_byte_addr[MEM_AW+3:4]};
  assign {cmd_instr, cmd_bl, cmd_addr} = cmd_dout;

  sync_fifo #(.W(CMD_W), .AW(CMD_AW)) u_cmd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.cmd_en),
    .din   (cmd_din),
    .pop   (cmd_pop),
    .dout  (cmd_dout),
    .full  (bus.cmd_full),
    .empty (bus.cmd_empty),
    .count (cmd_count)
  );

  logic [WR_W-1:0]    wr_dout;
  logic [DATA_W-1:0]  wr_word;
  logic [MASK_W-1:0]  wr_word_mask;
  logic               wr_pop;
  logic               wr_full_i;
  logic               wr_empty_i;

  assign {wr_word, wr_word_mask} = wr_dout;
  assign bus.wr_full  = wr_full_i;
  assign bus.wr_empty = wr_empty_i;

  sync_fifo #(.W(WR_W), .AW(FIFO_AW)) u_wr_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.wr_en),
    .din   ({bus.wr_data, bus.wr_mask}),
    .pop   (wr_pop),
    .dout  (wr_dout),
    .full  (wr_full_i),
    .empty (wr_empty_i),
    .count (bus.wr_count)
  );

  logic [DATA_W-1:0]  ram_q;
  logic               rd_vld;
  logic               rd_full_i;
  logic               rd_empty_i;
  logic [FIFO_AW:0]   rd_count_i;

  assign bus.rd_full  = rd_full_i;
  assign bus.rd_empty = rd_empty_i;
  assign bus.rd_count = rd_count_i;

  sync_fifo #(.W(DATA_W), .AW(FIFO_AW)) u_rd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rd_vld),
    .din   (ram_q),
    .pop   (bus.rd_en),
    .dout  (bus.rd_data),
    .full  (rd_full_i),
    .empty (rd_empty_i),
    .count (rd_count_i)
  );

  state_e             state;
  state_e             state_nxt;
  logic [BL_W-1:0]    beats_left;
  logic [MEM_AW-1:0]  ptr;
  logic               mem_we;
  logic               mem_re;
  logic               underrun_set;
  logic               issue_ok;
  logic               last_beat;
  logic               wr_underrun_q;
  logic               wr_error_q;
  logic               rd_error_q;

  // A read may issue only if the FIFO can absorb it plus the word still in the RAM pipe.
  assign issue_ok  = rd_vld ? (rd_count_i < (FIFO_AW+1)'(RD_DEPTH - 1)) : !rd_full_i;
  assign last_beat = (beats_left == '0);

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (cmd_pop) state_nxt = instr_target(cmd_instr);
      ST_WRITE:  if (wr_pop && last_beat) state_nxt = ST_IDLE;
      ST_READ:   if (mem_re && last_beat) state_nxt = ST_RDWAIT;
      ST_RDWAIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: every output of a combinational process gets a default first,
  // otherwise paths that skip an assignment infer latches.
  always_comb begin
    cmd_pop      = 1'b0;
    wr_pop       = 1'b0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    underrun_set = 1'b0;
    case (state)
      ST_IDLE:  cmd_pop = (cmd_count != '0);
      ST_WRITE: begin
        wr_pop       = !wr_empty_i;
        mem_we       = !wr_empty_i && !reset;
        underrun_set = wr_empty_i;
      end
      ST_READ:  mem_re = issue_ok;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beats_left <= '0;
      ptr        <= '0;
      rd_vld     <= 1'b0;
    end else begin
      rd_vld <= mem_re;
      if (cmd_pop) begin
        beats_left <= cmd_bl;
        ptr        <= cmd_addr;
      end else if (wr_pop || mem_re) begin
        beats_left <= beats_left - BL_W'(1);
        ptr        <= ptr + MEM_AW'(1);
      end
    end
  end

  // Backing store survives reset; a mask bit of 1 leaves that byte untouched.
  logic [DATA_W-1:0] mem [1 << MEM_AW];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (!wr_word_mask[b])
          mem[ptr][b*8 +: 8] <= wr_word[b*8 +: 8];
      end
    end
    if (mem_re)
      ram_q <= mem[ptr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_underrun_q <= 1'b0;
      wr_error_q    <= 1'b0;
      rd_error_q    <= 1'b0;
    end else begin
      if (underrun_set)
        wr_underrun_q <= 1'b1;
      if (bus.wr_en && wr_full_i && !wr_pop)
        wr_error_q <= 1'b1;
      if (bus.rd_en && rd_empty_i)
        rd_error_q <= 1'b1;
    end
  end

  assign bus.wr_underrun = wr_underrun_q;
  assign bus.wr_error    = wr_error_q;
  assign bus.rd_error    = rd_error_q;

endmodule

// File: tb/tb_mcb_bram_port.sv
// Scoreboard bench for mcb_bram_port: a reference memory model predicts read
// data at command time; words are compared as the DUT's read FIFO is drained.
module tb_mcb_bram_port;
  import mcb_port_pkg::*;

  localparam int DATA_W  = 128;
  localparam int MASK_W  = DATA_W / 8;
  localparam int MEM_AW  = 10;
  localparam int FIFO_AW = 6;
  localparam int CMD_AW  = 2;

  typedef logic [DATA_W-1:0] word_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mcb_bram_port_if #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW)) bus ();

  mcb_bram_port #(
    .DATA_W (DATA_W),
    .MEM_AW (MEM_AW),
    .FIFO_AW(FIFO_AW),
    .CMD_AW (CMD_AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  word_t             model [1 << MEM_AW];
  word_t             sb_q [$];
  word_t             wdat_q [$];
  logic [MASK_W-1:0] wmask_q [$];
  int                pend_beats = 0;
  logic [MEM_AW-1:0] pend_addr = '0;

  task automatic check(input string tag, input word_t got, input word_t exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Retire queued write words into the model against the outstanding write burst.
  task automatic apply_writes();
    word_t             d;
    logic [MASK_W-1:0] m;
    while (pend_beats > 0 && wdat_q.size() > 0) begin
      d = wdat_q.pop_front();
      m = wmask_q.pop_front();
      for (int b = 0; b < MASK_W; b++)
        if (!m[b]) model[pend_addr][b*8 +: 8] = d[b*8 +: 8];
      pend_addr++;
      pend_beats--;
    end
  endtask

  task automatic push_word(input word_t d, input logic [MASK_W-1:0] m, input bit dropped = 1'b0);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    bus.wr_mask = m;
    @(negedge clk);
    bus.wr_en = 1'b0;
    if (!dropped) begin
      wdat_q.push_back(d);
      wmask_q.push_back(m);
      apply_writes();
    end
  endtask

  // Returns at the negedge following the edge that sampled cmd_en.
  task automatic send_cmd(input logic [2:0] instr, input logic [5:0] bl, input logic [29:0] addr);
    logic [MEM_AW-1:0] wa;
    bus.cmd_en        = 1'b1;
    bus.cmd_instr     = instr;
    bus.cmd_bl        = bl;
    bus.cmd_byte_addr = addr;
    @(negedge clk);
    bus.cmd_en = 1'b0;
    wa = addr[MEM_AW+3:4];
    if (!instr[2]) begin
      if (instr[0]) begin
        for (int i = 0; i <= int'(bl); i++) begin
          sb_q.push_back(model[wa]);
          wa++;
        end
      end else begin
        pend_addr  = wa;
        pend_beats = int'(bl) + 1;
        apply_writes();
      end
    end
  endtask

  task automatic wait_engine(input string tag);
    int g = 0;
    while (!(bus.wr_empty && bus.cmd_empty) && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) check({tag, "_idle_timeout"}, word_t'(bus.wr_empty), 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic drain(input int n, input string tag);
    int got   = 0;
    int guard = 0;
    while (got < n && guard < 2000) begin
      if (!bus.rd_empty) begin
        if (sb_q.size() == 0) check({tag, "_sb_size"}, word_t'(sb_q.size()), 1);
        else                  check(tag, bus.rd_data, sb_q.pop_front());
        bus.rd_en = 1'b1;
        got++;
      end else begin
        bus.rd_en = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    bus.rd_en = 1'b0;
    check({tag, "_count"}, got, n);
  endtask

  // Read issued to an idle engine: first word visible only after the third edge.
  task automatic read_latency(input logic [5:0] bl, input logic [29:0] addr, input string tag);
    send_cmd(INSTR_RD, bl, addr);
    check({tag, "_cmd_empty_e0"}, bus.cmd_empty, 0);
    @(negedge clk);
    check({tag, "_cmd_empty_e1"}, bus.cmd_empty, 1);
    check({tag, "_rd_empty_e1"}, bus.rd_empty, 1);
    @(negedge clk);
    check({tag, "_rd_empty_e2"}, bus.rd_empty, 1);
    @(negedge clk);
    check({tag, "_rd_empty_e3"}, bus.rd_empty, 0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_cmd_empty"},   bus.cmd_empty,   1);
    check({tag, "_cmd_full"},    bus.cmd_full,    0);
    check({tag, "_wr_empty"},    bus.wr_empty,    1);
    check({tag, "_wr_full"},     bus.wr_full,     0);
    check({tag, "_wr_count"},    bus.wr_count,    0);
    check({tag, "_rd_empty"},    bus.rd_empty,    1);
    check({tag, "_rd_full"},     bus.rd_full,     0);
    check({tag, "_rd_count"},    bus.rd_count,    0);
    check({tag, "_wr_underrun"}, bus.wr_underrun, 0);
    check({tag, "_wr_error"},    bus.wr_error,    0);
    check({tag, "_rd_error"},    bus.rd_error,    0);
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish within cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    bus.cmd_en        = 1'b0;
    bus.cmd_instr     = '0;
    bus.cmd_bl        = '0;
    bus.cmd_byte_addr = '0;
    bus.wr_en         = 1'b0;
    bus.wr_data       = '0;
    bus.wr_mask       = '0;
    bus.rd_en         = 1'b0;
    reset             = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset_checks("rst");

    // Write 16 words then read them back; a no-op precedes the write.
    for (int i = 0; i < 16; i++)
      push_word({96'hC0DE_0000_1111_2222_3333_4444, 32'(i)}, '0);
    check("wr_count16", bus.wr_count, 16);
    send_cmd(INSTR_NOP, 6'd0, 30'h0);
    send_cmd(INSTR_WR, 6'd15, 30'h100);
    wait_engine("wr16");
    check("no_underrun", bus.wr_underrun, 0);
    read_latency(6'd15, 30'h100, "rd16");
    drain(16, "rd16");

    // Byte mask: only byte 0 of the second write lands.
    push_word({16{8'hAA}}, '0);
    send_cmd(INSTR_WR, 6'd0, 30'h200);
    wait_engine("mask_a");
    push_word({16{8'h55}}, 16'hFFFE);
    send_cmd(INSTR_WR, 6'd0, 30'h200);
    wait_engine("mask_b");
    send_cmd(INSTR_RD, 6'd0, 30'h200);
    drain(1, "mask");

    // Wrap at top of memory; sub-word and high address bits are ignored.
    for (int i = 0; i < 4; i++)
      push_word({96'hA5A5_0F0F_5A5A_F0F0_1234_5678, 32'(i)}, '0);
    send_cmd(INSTR_WR, 6'd3, 30'h2000_3FEF);
    wait_engine("wrap");
    send_cmd(INSTR_RD, 6'd1, 30'h3FE0);
    send_cmd(INSTR_RD, 6'd1, 30'h0000);
    drain(4, "wrap");

    // Fill the write FIFO, overflow it by one, then a full 64-beat burst.
    for (int i = 0; i < 64; i++)
      push_word({96'h5EED_0000_BEEF_0000_CAFE_0000, 32'(i)}, '0);
    check("wr_full", bus.wr_full, 1);
    check("wr_count64", bus.wr_count, 64);
    push_word({128{1'b1}}, '0, 1'b1);
    check("wr_error", bus.wr_error, 1);
    check("wr_count_after_drop", bus.wr_count, 64);
    send_cmd(INSTR_WR, 6'd63, 30'h400);
    wait_engine("wr64");

    // Backpressure: read 64 with rd_en held low.
    send_cmd(INSTR_RD, 6'd63, 30'h400);
    g = 0;
    while (!bus.rd_full && g < 400) begin
      @(negedge clk);
      g++;
    end
    repeat (5) @(negedge clk);
    check("rd_full", bus.rd_full, 1);
    check("rd_count64", bus.rd_count, 64);
    drain(64, "rd64");

    // Underrun: burst of 4 with only 2 words queued, then the rest.
    push_word({96'hDEAD_0000_0000_0000_0000_0000, 32'd0}, 16'h0F0F);
    push_word({96'hDEAD_1111_1111_1111_1111_1111, 32'd1}, '0);
    send_cmd(INSTR_WR, 6'd3, 30'h800);
    repeat (8) @(negedge clk);
    check("wr_underrun", bus.wr_underrun, 1);
    check("stall_wr_empty", bus.wr_empty, 1);
    push_word({96'hDEAD_2222_2222_2222_2222_2222, 32'd2}, '0);
    push_word({96'hDEAD_3333_3333_3333_3333_3333, 32'd3}, 16'h8001);
    wait_engine("underrun");
    check("wr_underrun_sticky", bus.wr_underrun, 1);
    send_cmd(INSTR_RD, 6'd3, 30'h800);
    drain(4, "underrun");

    // rd_en on an empty read FIFO.
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    check("rd_error", bus.rd_error, 1);
    check("rd_count_after_err", bus.rd_count, 0);

    // Reset during a 64-beat read; memory must survive.
    send_cmd(INSTR_RD, 6'd63, 30'h400);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
    pend_beats = 0;
    reset_checks("midrst");
    repeat (3) @(negedge clk);
    check("midrst_quiet", bus.rd_empty, 1);
    read_latency(6'd15, 30'h100, "post_rst");
    drain(16, "post_rst");

    check("sb_leftover", word_t'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mcb_bram_port.md
Name: mcb_bram_port

Overview:
- Responder-side model of one Spartan-6 MCB user port (p0 style: command, write-data and read-data FIFOs), backed by on-chip block RAM instead of LPDDR.
- Drop-in target for the cache-fill/write-back state machine on boards without DRAM, and for fast simulation of that state machine.
- Accepts burst read/write commands, drains the write FIFO into memory and fills the read FIFO from memory.

Parameters:
- DATA_W, 128, port data width in bits; mask width is DATA_W/8.
- MEM_AW, 10, log2 of backing memory depth in DATA_W-bit words.
- FIFO_AW, 6, log2 of write/read data FIFO depth (64 entries).
- CMD_AW, 2, log2 of command FIFO depth (4 entries).

Ports:
- clk  in  1  single clock for all port sides and memory.
- reset  in  1  synchronous, active-high.
- cmd_en  in  1  push command when high at clk edge.
- cmd_instr  in  3  [2]=1 no-op/refresh; else [0]=1 read, [0]=0 write.
- cmd_bl  in  6  burst length minus 1 (1..64 words).
- cmd_byte_addr  in  30  byte address.
- cmd_empty / cmd_full  out  1  command FIFO status.
- wr_en  in  1  push wr_data/wr_mask.
- wr_data  in  DATA_W  write word.
- wr_mask  in  DATA_W/8  1 = byte NOT written.
- wr_full / wr_empty  out  1  write FIFO status.
- wr_count  out  FIFO_AW+1  write FIFO occupancy.
- wr_underrun / wr_error  out  1  sticky error flags.
- rd_en  in  1  pop rd_data.
- rd_data  out  DATA_W  head of read FIFO, first-word-fall-through.
- rd_full / rd_empty  out  1  read FIFO status.
- rd_count  out  FIFO_AW+1  read FIFO occupancy.
- rd_error  out  1  sticky error flag.

Behaviour:
- Reset values:
  - All FIFOs flushed; empty flags 1, full flags 0, counts 0.
  - Sticky flags 0; FSM in IDLE.
  - Memory contents retained, not cleared.
- Reset mid-burst: remaining beats are abandoned and no further memory writes occur.
- Addressing:
  - Word address = cmd_byte_addr[MEM_AW+3:4].
  - cmd_byte_addr[3:0] and bits above MEM_AW+3 are ignored.
  - Beat i uses (word address + i) mod 2^MEM_AW, so bursts wrap at the top of memory.
- Command FIFO:
  - cmd_en while cmd_full: command dropped, no flag.
  - cmd_empty deasserts on the edge after the push.
- FSM states: IDLE, WRITE, READ, RDWAIT.
- IDLE:
  - When the command FIFO is non-empty, pop it, load the beat counter with bl and the word pointer with the address.
  - Go to WRITE if instr[2:0] is 0x0 or 0x2, READ if 0x1 or 0x3.
  - instr[2]=1: pop and stay in IDLE (one-cycle no-op).
- WRITE:
  - Each cycle the write FIFO is non-empty: pop one word and write it to memory with per-byte enable ~wr_mask.
  - Advance the pointer; after the last beat, return to IDLE.
  - Write FIFO empty in WRITE: stall and set wr_underrun (sticky). No garbage is written.
- READ:
  - Issue a memory read each cycle the read FIFO has space for all in-flight words (registered 1-cycle RAM latency).
  - Push the returned word into the read FIFO.
  - After the last issue, go to RDWAIT for one cycle, then to IDLE.
  - Read FIFO full: stall issue. The block never overflows.
- Latency, idle engine, read:
  - cmd_en sampled at edge 0; command popped at edge 1; RAM address issued at edge 2; word pushed at edge 3.
  - rd_empty=0 after edge 3; subsequent beats follow one per clk.
- Latency, write: memory is updated for beat 0 at edge 2 after cmd_en, given data is already in the write FIFO.
- FIFO edge cases:
  - Simultaneous push and pop on the same FIFO in one cycle: both happen, count unchanged (legal when full or empty only if the pop is valid).
  - wr_en while wr_full: word dropped, wr_error sticky set.
  - rd_en while rd_empty: ignored, rd_error sticky set.
- Read-after-write: commands execute strictly in order, so a read queued after a write to the same address returns the new data.

Decomposition:
- Shared package mcb_port_pkg holds:
  - instruction encodings (INSTR_WR=3'b000, INSTR_RD=3'b001, INSTR_NOP bit 2);
  - FSM state constants;
  - DATA_W default.
- Sub-module sync_fifo (parameterised width/depth, FWFT, count/full/empty) is instanced three times: command FIFO, write FIFO, read FIFO.
- The byte-enabled RAM stays inline.

Test Plan:
- Write then read:
  - Stimulus: push 16 words 0x..00..0x..0F; cmd write bl=15 addr=0x100; then cmd read bl=15 addr=0x100.
  - Response: rd_data returns the same 16 words in order; rd_empty first low 3 edges after the read cmd_en when idle.
- Byte mask:
  - Stimulus: memory word at 0x200 holds all 0xAA; write one word of all 0x55 with wr_mask=0xFFFE; read it back.
  - Response: byte 0 = 0x55, bytes 1..15 = 0xAA.
- Wrap:
  - Stimulus: MEM_AW=10; write bl=3 at byte_addr=0x3FE0; read word addresses 0x3FE, 0x3FF, 0x000, 0x001.
  - Response: those four words hold the written data.
- Backpressure:
  - Stimulus: read bl=63, then hold rd_en low.
  - Response: rd_full=1, rd_count=64, no data loss; after draining, all 64 words arrive in order.
- Errors:
  - Stimulus: write cmd bl=3 with only 2 words queued.
  - Response: wr_underrun=1, engine stalls; the 2 further words then complete the burst.
  - Stimulus: rd_en on empty.
  - Response: rd_error=1.
- Reset mid-burst:
  - Stimulus: assert reset during a 64-beat read.
  - Response: next cycle all FIFOs empty, flags 0, FSM IDLE; earlier-written memory data still readable.
